// File: rtl/dsp_acc_cascade_array_if.sv
// Sample/result bundle for dsp_acc_cascade_array.
// The master drives the tap operands; the slave (the accumulator) returns the results.
interface dsp_acc_cascade_array_if #(
   parameter int N_TAPS = 4,
   parameter int IN_W   = 18,
   parameter int ACC_W  = 48,
   parameter int OUT_W  = 16
);
   logic                     in_valid;
   logic [N_TAPS*IN_W-1:0]   op;
   logic [N_TAPS-1:0]        cin;
   logic                     mode;
   logic signed [ACC_W-1:0]  result;
   logic                     result_valid;
   logic signed [OUT_W-1:0]  out_sat;
   logic                     out_ovf;
   logic                     out_valid;

   modport master (
      output in_valid, op, cin, mode,
      input  result, result_valid, out_sat, out_ovf, out_valid
   );
   modport slave (
      input  in_valid, op, cin, mode,
      output result, result_valid, out_sat, out_ovf, out_valid
   );
endinterface

// File: rtl/dsp_acc_cascade_array.sv
// Skewed systolic cascade adder over N_TAPS signed operands with per-tap carry,
// followed by a preload/accumulate register and a round/shift/saturate stage.
module dsp_acc_cascade_array #(
   parameter int N_TAPS     = 4,
   parameter int IN_W       = 18,
   parameter int ACC_W      = 48,
   parameter int OUT_W      = 16,
   parameter int FRAC_SHIFT = 0
) (
   input  logic clk,
   input  logic areset,
   input  logic clken,
   input  logic dsp_reset,
   dsp_acc_cascade_array_if.slave bus
);
   localparam logic signed [ACC_W:0] RND     = ((ACC_W+1)'(1) << FRAC_SHIFT) >> 1;
   localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

   // dsp_reset must clear state even while clken is low
   logic upd;
   assign upd = clken | dsp_reset;

   // vld_pipe: [0] in1, [1] in2, [2+k] cascade stage k, [N+2] result, [N+3] out
   logic [N_TAPS+3:0]               vld_pipe_q, vld_pipe_d;
   logic [N_TAPS+1:0]               mode_pipe_q, mode_pipe_d;
   logic [N_TAPS*IN_W-1:0]          op1_q, op1_d, op2_q, op2_d;
   logic [N_TAPS-1:0]               cin1_q, cin1_d, cin2_q, cin2_d;
   logic [N_TAPS-1:0][IN_W-1:0]     tap_op;
   logic [N_TAPS-1:0]               tap_cin;
   logic [N_TAPS-1:0][ACC_W-1:0]    s_q, s_d;
   logic [ACC_W-1:0]                p_q, p_d;
   logic signed [OUT_W-1:0]         osat_q, osat_d;
   logic                            ovf_q, ovf_d;
   logic signed [ACC_W:0]           t_sum, t_sh;

   for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
      if (k == 0) begin : g_direct
         assign tap_op[k]  = op2_q[k*IN_W +: IN_W];
         assign tap_cin[k] = cin2_q[k];
      end else begin : g_skew
         // k extra registers align tap k with the partial sum reaching stage k
         logic [k-1:0][IN_W-1:0] sk_op_q, sk_op_d;
         logic [k-1:0]           sk_cin_q, sk_cin_d;
         always_comb begin
            sk_op_d     = '0;
            sk_cin_d    = '0;
            sk_op_d[0]  = op2_q[k*IN_W +: IN_W];
            sk_cin_d[0] = cin2_q[k];
            for (int j = 1; j < k; j++) begin
               sk_op_d[j]  = sk_op_q[j-1];
               sk_cin_d[j] = sk_cin_q[j-1];
            end
            if (dsp_reset) begin
               sk_op_d  = '0;
               sk_cin_d = '0;
            end
         end
         always_ff @(posedge clk or posedge areset) begin
            if (areset) begin
               sk_op_q  <= '0;
               sk_cin_q <= '0;
            end else if (upd) begin
               sk_op_q  <= sk_op_d;
               sk_cin_q <= sk_cin_d;
            end
         end
         assign tap_op[k]  = sk_op_q[k-1];
         assign tap_cin[k] = sk_cin_q[k-1];
      end
   end

   always_comb begin
      vld_pipe_d  = {vld_pipe_q[N_TAPS+2:0], bus.in_valid};
      mode_pipe_d = {mode_pipe_q[N_TAPS:0], bus.mode};
      op1_d  = bus.op;
      cin1_d = bus.cin;
      op2_d  = op1_q;
      cin2_d = cin1_q;
      for (int k = 0; k < N_TAPS; k++)
         s_d[k] = (k == 0 ? ACC_W'(0) : s_q[(k == 0) ? 0 : k-1])
                + ACC_W'(signed'(tap_op[k])) + ACC_W'(tap_cin[k]);

      p_d = p_q;
      if (vld_pipe_q[N_TAPS+1])
         p_d = mode_pipe_q[N_TAPS+1] ? p_q + s_q[N_TAPS-1] : s_q[N_TAPS-1];

      // one guard bit so the rounding add cannot wrap before saturation
      t_sum  = $signed({p_q[ACC_W-1], p_q}) + RND;
      t_sh   = t_sum >>> FRAC_SHIFT;
      osat_d = osat_q;
      ovf_d  = ovf_q;
      if (vld_pipe_q[N_TAPS+2]) begin
         if (t_sh > SAT_MAX) begin
            osat_d = SAT_MAX[OUT_W-1:0];
            ovf_d  = 1'b1;
         end else if (t_sh < SAT_MIN) begin
            osat_d = SAT_MIN[OUT_W-1:0];
            ovf_d  = 1'b1;
         end else begin
            osat_d = t_sh[OUT_W-1:0];
            ovf_d  = 1'b0;
         end
      end

      if (dsp_reset) begin
         vld_pipe_d  = '0;
         mode_pipe_d = '0;
         op1_d  = '0;
         cin1_d = '0;
         op2_d  = '0;
         cin2_d = '0;
         s_d    = '0;
         p_d    = '0;
         osat_d = '0;
         ovf_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         vld_pipe_q  <= '0;
         mode_pipe_q <= '0;
         op1_q  <= '0;
         cin1_q <= '0;
         op2_q  <= '0;
         cin2_q <= '0;
         s_q    <= '0;
         p_q    <= '0;
         osat_q <= '0;
         ovf_q  <= 1'b0;
      end else if (upd) begin
         vld_pipe_q  <= vld_pipe_d;
         mode_pipe_q <= mode_pipe_d;
         op1_q  <= op1_d;
         cin1_q <= cin1_d;
         op2_q  <= op2_d;
         cin2_q <= cin2_d;
         s_q    <= s_d;
         p_q    <= p_d;
         osat_q <= osat_d;
         ovf_q  <= ovf_d;
      end
   end

   assign bus.result       = p_q;
   assign bus.result_valid = vld_pipe_q[N_TAPS+2];
   assign bus.out_sat      = osat_q;
   assign bus.out_ovf      = ovf_q;
   assign bus.out_valid    = vld_pipe_q[N_TAPS+3];
endmodule
